// File: rtl/sp_comma_align_if.sv
// Receive-side bundle for the comma aligner: serial bit in, aligned symbol
// and status out.
interface sp_comma_align_if;
    logic       IS;
    logic [9:0] OP;
    logic       VALID;
    logic       COMMA;
    logic       LOCKED;

    modport master (
        output IS,
        input  OP,
        input  VALID,
        input  COMMA,
        input  LOCKED
    );

    modport slave (
        input  IS,
        output OP,
        output VALID,
        output COMMA,
        output LOCKED
    );
endinterface

// File: rtl/sp_comma_align.sv
// Serial-to-parallel 8b/10b receiver front end: deserialises LSB first, aligns
// to K28.5 commas and tracks lock, dropping it after repeated misplaced commas.
module sp_comma_align #(
    parameter logic [9:0] COMMA_NEG = 10'h17C,
    parameter logic [9:0] COMMA_POS = 10'h283,
    parameter int         MAX_ERR   = 4
) (
    input  logic             CLOCK,
    input  logic             RESET,
    sp_comma_align_if.slave  io
);

    localparam int                ERR_W       = $clog2(MAX_ERR + 1);
    localparam logic [ERR_W-1:0]  ERR_LAST    = ERR_W'(MAX_ERR - 1);
    localparam logic [0:0]        ST_UNLOCKED = 1'b0;
    localparam logic [0:0]        ST_LOCKED   = 1'b1;

    logic [9:0]       r_sr;
    logic [3:0]       r_cnt;
    logic [ERR_W-1:0] r_err;
    logic [0:0]       r_state;
    logic [9:0]       r_op;
    logic             r_valid;
    logic             r_comma;
    logic             r_locked;

    logic             w_match;
    logic [9:0]       w_sr_nxt;
    logic [3:0]       w_cnt_nxt;
    logic [ERR_W-1:0] w_err_nxt;
    logic [0:0]       w_state_nxt;
    logic [9:0]       w_op_nxt;
    logic             w_valid_nxt;
    logic             w_comma_nxt;
    logic             w_locked_nxt;

    // Comma detect on the symbol window held before the current edge.
    always_comb begin
        w_match = (r_sr == COMMA_NEG) || (r_sr == COMMA_POS);
    end

    // Next-state decode for alignment, lock tracking and symbol output.
    always_comb begin
        w_sr_nxt     = {io.IS, r_sr[9:1]};
        w_cnt_nxt    = (r_cnt == 4'd9) ? 4'd0 : (r_cnt + 4'd1);
        w_err_nxt    = r_err;
        w_state_nxt  = r_state;
        w_op_nxt     = r_op;
        w_valid_nxt  = 1'b0;
        w_comma_nxt  = 1'b0;
        w_locked_nxt = r_locked;

        case (r_state)
            ST_UNLOCKED: begin
                w_locked_nxt = 1'b0;
                if (w_match) begin
                    // A comma at any offset defines the new boundary; the
                    // counter restarts so it reads 0 ten edges from now.
                    w_op_nxt     = r_sr;
                    w_valid_nxt  = 1'b1;
                    w_comma_nxt  = 1'b1;
                    w_locked_nxt = 1'b1;
                    w_cnt_nxt    = 4'd1;
                    w_err_nxt    = {ERR_W{1'b0}};
                    w_state_nxt  = ST_LOCKED;
                end else begin
                    w_state_nxt  = ST_UNLOCKED;
                end
            end
            ST_LOCKED: begin
                if (r_cnt == 4'd0) begin
                    w_op_nxt    = r_sr;
                    w_valid_nxt = 1'b1;
                    w_comma_nxt = w_match;
                    if (w_match) begin
                        w_err_nxt = {ERR_W{1'b0}};
                    end else begin
                        w_err_nxt = r_err;
                    end
                end else if (w_match) begin
                    // Misplaced comma: count it, give up lock on the last one
                    // without realigning to it.
                    if (r_err == ERR_LAST) begin
                        w_err_nxt    = {ERR_W{1'b0}};
                        w_locked_nxt = 1'b0;
                        w_state_nxt  = ST_UNLOCKED;
                    end else begin
                        w_err_nxt    = r_err + ERR_W'(1);
                    end
                end else begin
                    w_err_nxt = r_err;
                end
            end
            default: begin
                w_err_nxt    = {ERR_W{1'b0}};
                w_locked_nxt = 1'b0;
                w_state_nxt  = ST_UNLOCKED;
            end
        endcase
    end

    // State and output registers; reset discards any partial symbol.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            r_sr     <= 10'd0;
            r_cnt    <= 4'd0;
            r_err    <= {ERR_W{1'b0}};
            r_state  <= ST_UNLOCKED;
            r_op     <= 10'd0;
            r_valid  <= 1'b0;
            r_comma  <= 1'b0;
            r_locked <= 1'b0;
        end else begin
            r_sr     <= w_sr_nxt;
            r_cnt    <= w_cnt_nxt;
            r_err    <= w_err_nxt;
            r_state  <= w_state_nxt;
            r_op     <= w_op_nxt;
            r_valid  <= w_valid_nxt;
            r_comma  <= w_comma_nxt;
            r_locked <= w_locked_nxt;
        end
    end

    assign io.OP     = r_op;
    assign io.VALID  = r_valid;
    assign io.COMMA  = r_comma;
    assign io.LOCKED = r_locked;

endmodule

// File: tb/tb_sp_comma_align.sv
// Bench for sp_comma_align: directed scenarios plus random symbol streams,
// checked edge by edge against a bit-history reference model.
module tb_sp_comma_align;

    localparam logic [9:0] C_NEG   = 10'h17C;
    localparam logic [9:0] C_POS   = 10'h283;
    localparam int         MAX_ERR = 4;

    logic CLOCK = 1'b0;
    logic RESET = 1'b1;
    sp_comma_align_if bus ();

    sp_comma_align #(.COMMA_NEG(C_NEG), .COMMA_POS(C_POS), .MAX_ERR(MAX_ERR)) dut (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .io    (bus)
    );

    always #5 CLOCK = ~CLOCK;

    int checks   = 0;
    int failures = 0;

    // Reference model: full history of sampled bits since reset, the bit
    // count at which lock was taken, and a misplaced-comma tally.
    bit         hist[$];
    logic       m_locked;
    int         m_anchor;
    int         m_err;
    logic [9:0] m_op;
    logic       m_valid;
    logic       m_comma;
    logic       prev_valid;

    task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        m_locked   = 1'b0;
        m_anchor   = 0;
        m_err      = 0;
        m_op       = 10'd0;
        m_valid    = 1'b0;
        m_comma    = 1'b0;
        prev_valid = 1'b0;
    endtask

    // The last ten bits received, oldest in bit 0; missing bits read as 0.
    function automatic logic [9:0] window();
        logic [9:0] w;
        int n;
        n = hist.size();
        for (int i = 0; i < 10; i++) begin
            int j;
            j = n - 10 + i;
            w[i] = (j >= 0) ? hist[j] : 1'b0;
        end
        return w;
    endfunction

    task automatic model_step();
        logic [9:0] w;
        logic       is_comma;
        int         n;
        n        = hist.size();
        w        = window();
        is_comma = (w == C_NEG) || (w == C_POS);
        m_valid  = 1'b0;
        m_comma  = 1'b0;
        if (!m_locked) begin
            if (is_comma) begin
                m_locked = 1'b1;
                m_anchor = n;
                m_err    = 0;
                m_op     = w;
                m_valid  = 1'b1;
                m_comma  = 1'b1;
            end
        end else if (((n - m_anchor) % 10) == 0) begin
            m_op    = w;
            m_valid = 1'b1;
            m_comma = is_comma;
            if (is_comma) m_err = 0;
        end else if (is_comma) begin
            m_err++;
            if (m_err == MAX_ERR) begin
                m_locked = 1'b0;
                m_err    = 0;
            end
        end
    endtask

    task automatic compare_all(input string ph);
        chk({ph, "_op"},     bus.OP,                   m_op);
        chk({ph, "_valid"},  {9'd0, bus.VALID},        {9'd0, m_valid});
        chk({ph, "_comma"},  {9'd0, bus.COMMA},        {9'd0, m_comma});
        chk({ph, "_locked"}, {9'd0, bus.LOCKED},       {9'd0, m_locked});
        chk({ph, "_vpair"},  {9'd0, bus.VALID & prev_valid}, 10'd0);
        chk({ph, "_cimpv"},  {9'd0, bus.COMMA & ~bus.VALID},  10'd0);
        prev_valid = bus.VALID;
    endtask

    task automatic send_bit(input logic b);
        model_step();
        bus.IS = b;
        @(posedge CLOCK);
        hist.push_back(b);
        #1;
        compare_all("edge");
    endtask

    task automatic send_sym(input logic [9:0] s);
        for (int i = 0; i < 10; i++) send_bit(s[i]);
    endtask

    task automatic send_sym_tail(input logic [9:0] s);
        for (int i = 1; i < 10; i++) send_bit(s[i]);
    endtask

    task automatic async_reset();
        #3;
        RESET = 1'b1;
        #1;
        model_reset();
        compare_all("areset");
        repeat (2) begin
            @(posedge CLOCK);
            #1;
            compare_all("rhold");
        end
        RESET = 1'b0;
    endtask

    initial begin
        logic [9:0] s;
        int         r;
        bus.IS = 1'b0;
        model_reset();
        repeat (2) @(posedge CLOCK);
        #1;
        compare_all("reset");
        RESET = 1'b0;

        // Some bits, then reset mid-stream and idle.
        for (int i = 0; i < 7; i++) send_bit(1'($urandom_range(0, 1)));
        async_reset();
        repeat (30) send_bit(1'b0);
        chk("idle_locked", {9'd0, bus.LOCKED}, 10'd0);

        // Initial alignment on RD- comma.
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        send_sym(C_NEG);
        s = 10'h2AA;
        send_bit(s[0]);
        chk("align_op",     bus.OP,                 10'h17C);
        chk("align_comma",  {9'd0, bus.COMMA},      10'd1);
        chk("align_locked", {9'd0, bus.LOCKED},     10'd1);
        send_sym_tail(s);
        s = 10'h155;
        send_bit(s[0]);
        chk("sym2_op",    bus.OP,            10'h2AA);
        chk("sym2_comma", {9'd0, bus.COMMA}, 10'd0);
        send_sym_tail(s);
        send_bit(1'b0);
        chk("sym3_op",    bus.OP,            10'h155);
        chk("sym3_valid", {9'd0, bus.VALID}, 10'd1);

        // RD+ comma from a fresh reset.
        async_reset();
        send_sym(C_POS);
        s = 10'h0F5;
        send_bit(s[0]);
        chk("rdp_op",    bus.OP,            10'h283);
        chk("rdp_comma", {9'd0, bus.COMMA}, 10'd1);
        send_sym_tail(s);
        send_bit(1'b1);
        chk("rdp_data", bus.OP, 10'h0F5);
        for (int i = 1; i < 10; i++) send_bit(1'b1);

        // Lock hold on an alternating stream.
        for (int i = 0; i < 50; i++) begin
            case (i % 3)
                0:       send_sym(C_NEG);
                1:       send_sym(C_POS);
                default: send_sym(10'h2AA);
            endcase
        end
        chk("hold_locked", {9'd0, bus.LOCKED}, 10'd1);

        // Slip by one bit, four misplaced commas lose lock, next comma relocks.
        send_bit(1'b0);
        repeat (3) send_sym(C_NEG);
        chk("slip3_locked", {9'd0, bus.LOCKED}, 10'd1);
        send_sym(C_NEG);
        s = C_NEG;
        send_bit(s[0]);
        chk("loss_locked", {9'd0, bus.LOCKED}, 10'd0);
        send_sym_tail(s);
        send_bit(1'b0);
        chk("relock_op",     bus.OP,             C_NEG);
        chk("relock_locked", {9'd0, bus.LOCKED}, 10'd1);
        for (int i = 1; i < 10; i++) send_bit(1'b0);
        send_sym(10'h2AA);

        // Error tally cleared by a boundary comma.
        send_bit(1'b0);
        repeat (3) send_sym(C_NEG);
        repeat (9) send_bit(1'b0);
        send_sym(C_NEG);
        send_bit(1'b0);
        repeat (3) send_sym(C_NEG);
        send_sym(10'h2AA);
        chk("errclr_locked", {9'd0, bus.LOCKED}, 10'd1);

        // Random mix of commas, data and slips.
        for (int i = 0; i < 200; i++) begin
            r = $urandom_range(0, 9);
            if (r < 3)       send_sym(($urandom_range(0, 1) == 0) ? C_NEG : C_POS);
            else if (r < 7)  send_sym(10'($urandom));
            else if (r == 7) repeat ($urandom_range(1, 9)) send_bit(1'($urandom_range(0, 1)));
            else if (r == 8) send_sym(10'h2AA);
            else             send_sym(10'h155);
        end
        async_reset();
        repeat (12) send_bit(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sp_comma_align.md
Name: sp_comma_align

Overview:
- 10-bit serial-to-parallel receiver with 8b/10b comma (K28.5) symbol alignment. It sits on the PHY receive path after the serial line and ahead of the 8b/10b decoder.
- It shifts in one bit per CLOCK, LSB first: the first bit received is OP[0]. It finds the symbol boundary from a comma and then emits one aligned 10-bit symbol every 10 clocks.
- It tracks lock and drops it after repeated off-boundary commas.

Parameters:
- COMMA_NEG, 10'h17C, K28.5 RD- as a parallel word (bit 0 = first bit on the line, "a").
- COMMA_POS, 10'h283, K28.5 RD+ as a parallel word.
- MAX_ERR, 4, number of consecutive off-boundary commas that forces loss of lock (must be ≥1).

Ports:
- CLOCK  input  1  bit clock; all state updates on posedge.
- RESET  input  1  asynchronous, active-high reset.
- IS  input  1  serial data bit, sampled on posedge CLOCK.
- OP  output  10  aligned parallel symbol.
- VALID  output  1  one-cycle pulse: OP holds a new symbol.
- COMMA  output  1  high with VALID when OP equals COMMA_NEG or COMMA_POS.
- LOCKED  output  1  symbol alignment established.

Behaviour:
- Reset: asynchronous, active-high.
  - While RESET=1: OP=0, VALID=0, COMMA=0, LOCKED=0, shift register=0, bit counter=0, error counter=0, state=UNLOCKED.
  - Takes effect immediately mid-symbol; nothing of the partial symbol is retained.
- Shift register SR[9:0], every posedge: SR <= {IS, SR[9:1]}.
- Comma match:
  - MATCH is combinational: MATCH = (SR==COMMA_NEG) || (SR==COMMA_POS).
  - It is evaluated on the registered SR, i.e. the value before the current edge.
- Bit counter CNT, range 0..9:
  - Increments each posedge and wraps 9->0.
  - CNT==0 means SR holds a complete symbol on the current boundary.
- State UNLOCKED:
  - VALID=0, LOCKED=0 each cycle; CNT free-runs and is ignored.
  - On an edge with MATCH=1: OP<=SR, VALID<=1, COMMA<=1, LOCKED<=1, CNT<=1, ERR<=0, go to LOCKED.
- State LOCKED, edge with CNT==0:
  - OP<=SR, VALID<=1, COMMA<=MATCH.
  - If MATCH=1, ERR<=0.
- State LOCKED, edge with CNT!=0:
  - VALID<=0, COMMA<=0, OP holds.
  - If MATCH=1, ERR<=ERR+1. If ERR+1==MAX_ERR: go to UNLOCKED, LOCKED<=0, ERR<=0, no realignment on that comma.
- Latency: the 10th (last) bit of a symbol is sampled at edge k; OP/VALID are updated at edge k+1. Symbols appear exactly every 10 edges while LOCKED.
- ERR width is $clog2(MAX_ERR+1). It is cleared only by a boundary comma or by lock loss, not by non-comma boundary symbols.
- A boundary comma and an off-boundary comma are mutually exclusive in the same cycle (CNT decides).
- VALID is never high two consecutive cycles. COMMA=1 implies VALID=1.
- After loss of lock, the next comma at any offset realigns. During UNLOCKED, data is discarded.

Test Plan:
- Reset and idle: RESET=1 mid-stream, then release and drive IS=0 for 30 clocks -> OP=0, VALID/COMMA/LOCKED stay 0 throughout; outputs go to 0 asynchronously, before the next edge.
- Initial alignment: 3 junk bits (1,0,1), then 0x17C LSB first, then 0x2AA and 0x155 -> one edge after the comma's last bit: OP=0x17C, VALID=1, COMMA=1, LOCKED=1. Then OP=0x2AA and OP=0x155 at +10 and +20 edges, each with VALID=1 and COMMA=0.
- RD+ comma: 0x283 followed by 0x0F5 -> lock on 0x283 with COMMA=1, then OP=0x0F5 ten edges later.
- Lock hold: locked stream alternating 0x17C,0x283,0x2AA for 50 symbols -> LOCKED stays 1, VALID exactly every 10 edges, COMMA set on each comma symbol.
- Slip and loss: after lock, insert 1 extra bit, then send 4 commas -> LOCKED falls at the edge after the 4th comma's last bit, with no VALID for those commas. The next comma relocks at the new offset with OP=comma.
- Error clear: after lock, slip by 1 bit and send 3 commas, then re-slip to the boundary and send 1 comma, then slip and send 3 more commas -> LOCKED stays 1 because ERR was cleared by the boundary comma.
